// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module   : dcache_controller
// Purpose  : Direct-mapped, write-back, write-allocate data cache controller
//            sitting in the MEM stage. Owns tag/valid/dirty/data arrays and
//            sequences victim writeback and line fill on a miss.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_controller #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256,
    parameter int TAG_W     = 22
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_write_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i
);

    // Address field geometry derived from the cache shape.
    localparam int c_IDX_W   = $clog2(NUM_LINES);
    localparam int c_OFF_W   = $clog2(LINE_BITS / 8);
    localparam int c_WORD_W  = c_OFF_W - 2;
    localparam int c_LINE_AW = $clog2(LINE_BITS);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WRITEBACK = 2'd1;
    localparam logic [1:0] c_ALLOCATE  = 2'd2;

    logic [1:0]           r_state;
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_BITS-1:0] r_data [NUM_LINES];

    // Miss context is latched so the memory address stays stable even if the
    // requester drops or changes its request mid-miss.
    logic [TAG_W-1:0]     r_victim_tag;
    logic [TAG_W-1:0]     r_miss_tag;
    logic [c_IDX_W-1:0]   r_miss_idx;

    logic [TAG_W-1:0]     w_tag;
    logic [c_IDX_W-1:0]   w_idx;
    logic [c_WORD_W-1:0]  w_word;
    logic [c_LINE_AW-1:0] w_bit_sel;
    logic [LINE_BITS-1:0] w_line;
    logic [31:0]          w_word_rd;
    logic                 w_hit;
    logic                 w_idle;
    logic                 w_store_hit;
    logic                 w_fill;
    logic                 w_unused_addr;

    assign w_tag         = cpu_addr_i[31 -: TAG_W];
    assign w_idx         = cpu_addr_i[c_OFF_W +: c_IDX_W];
    assign w_word        = cpu_addr_i[2 +: c_WORD_W];
    assign w_unused_addr = ^cpu_addr_i[1:0];
    assign w_bit_sel     = {w_word, 5'd0};
    assign w_line        = r_data[w_idx];
    assign w_word_rd     = w_line[w_bit_sel +: 32];
    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_idle        = (r_state == c_IDLE);
    assign w_store_hit   = w_idle && cpu_req_i && cpu_write_i && w_hit;
    assign w_fill        = (r_state == c_ALLOCATE) && mem_ack_i;

    // Output decode: CPU side answers only on an IDLE hit, memory side is
    // driven only while a line transaction is outstanding.
    always_comb begin
        cpu_rdata_o = 32'd0;
        cpu_stall_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = '0;
        case (r_state)
            c_IDLE: begin
                cpu_stall_o = cpu_req_i && !w_hit;
                if (cpu_req_i && !cpu_write_i && w_hit) begin
                    cpu_rdata_o = w_word_rd;
                end
            end
            c_WRITEBACK: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = {r_victim_tag, r_miss_idx, {c_OFF_W{1'b0}}};
                mem_wdata_o = r_data[r_miss_idx];
            end
            c_ALLOCATE: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {r_miss_tag, r_miss_idx, {c_OFF_W{1'b0}}};
            end
            default: begin
                cpu_stall_o = 1'b1;
            end
        endcase
    end

    // Tag/data arrays: line install on fill ack, word merge on store hit.
    // Not cleared by reset, but a reset cycle blocks any update.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (w_fill) begin
                r_data[r_miss_idx] <= mem_rdata_i;
                r_tag[r_miss_idx]  <= r_miss_tag;
            end else if (w_store_hit) begin
                r_data[w_idx][w_bit_sel +: 32] <= cpu_wdata_i;
            end
        end
    end

    // Miss-handling FSM plus valid/dirty bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= c_IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_victim_tag <= '0;
            r_miss_tag   <= '0;
            r_miss_idx   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (cpu_req_i) begin
                        if (w_hit) begin
                            if (cpu_write_i) begin
                                r_dirty[w_idx] <= 1'b1;
                            end
                        end else begin
                            r_victim_tag <= r_tag[w_idx];
                            r_miss_tag   <= w_tag;
                            r_miss_idx   <= w_idx;
                            r_state      <= (r_valid[w_idx] && r_dirty[w_idx]) ?
                                            c_WRITEBACK : c_ALLOCATE;
                        end
                    end
                end
                c_WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_dirty[r_miss_idx] <= 1'b0;
                        r_state             <= c_ALLOCATE;
                    end
                end
                c_ALLOCATE: begin
                    if (mem_ack_i) begin
                        r_valid[r_miss_idx] <= 1'b1;
                        r_dirty[r_miss_idx] <= 1'b0;
                        r_state             <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-back, write-allocate data cache controller in the MEM stage, between the CPU load/store path and the slow line-wide data memory.
- Owns the tag, valid, dirty and data arrays and sequences miss handling.
- cpu_stall_o is the mem_stall signal that freezes the PC and all pipeline registers (IF/ID through MEM/WB) while a miss is serviced.

Parameters:
NUM_LINES, 32, number of cache lines (index width log2 = 5)
LINE_BITS, 256, line size in bits (8 words, 32 bytes)
TAG_W, 22, tag width = 32 - 5 index - 5 offset

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous, active-high reset
cpu_req_i  input  1  load/store valid in MEM stage
cpu_write_i  input  1  1 = store, 0 = load
cpu_addr_i  input  32  byte address; tag [31:10], index [9:5], word [4:2], [1:0] ignored
cpu_wdata_i  input  32  store data
cpu_rdata_o  output  32  load data, valid when cpu_req_i && !cpu_stall_o
cpu_stall_o  output  1  request not yet serviceable; pipeline must hold
mem_req_o  output  1  memory transaction request, held until mem_ack_i
mem_write_o  output  1  1 = line writeback, 0 = line fetch
mem_addr_o  output  32  line-aligned address ([4:0] = 0)
mem_wdata_o  output  256  line being written back
mem_rdata_i  input  256  fetched line, valid with mem_ack_i
mem_ack_i  input  1  one-cycle completion pulse, latency arbitrary (>= 1 cycle)

Behaviour:
- Reset (rst_i high at posedge): state = IDLE; all valid and dirty bits = 0; tag and data arrays not cleared.
- Output values in IDLE after reset: mem_req_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_wdata_o = 0, cpu_rdata_o = 0, cpu_stall_o = 0 unless cpu_req_i is asserted.
- hit = valid[index] && tag[index] == addr tag.
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE, cpu_req_i && hit:
  - cpu_stall_o = 0 combinationally.
  - Load: cpu_rdata_o = data[index] word [4:2], same cycle.
  - Store: word written at the posedge and dirty[index] = 1.
- IDLE, cpu_req_i && !hit:
  - cpu_stall_o = 1 combinationally, same cycle.
  - Next state is WRITEBACK if valid && dirty, else ALLOCATE.
  - The victim tag is captured in that cycle.
- WRITEBACK:
  - mem_req_o = 1, mem_write_o = 1.
  - mem_addr_o = {victim tag, index, 5'b0}, mem_wdata_o = data[index].
  - On mem_ack_i: clear dirty[index], go to ALLOCATE.
- ALLOCATE:
  - mem_req_o = 1, mem_write_o = 0, mem_addr_o = {req tag, index, 5'b0}.
  - On mem_ack_i, at the same edge: data[index] = mem_rdata_i, tag updated, valid = 1, dirty = 0. Go to IDLE.
- The original request re-evaluates as a hit in IDLE on the cycle after ack. A store merges then and sets dirty.
- cpu_stall_o = 1 throughout WRITEBACK and ALLOCATE, including the ack cycle.
- Latency: hit 0 stall cycles. Clean miss stall = fetch latency + 1. Dirty miss stall = writeback latency + fetch latency + 1.
- Requester holds cpu_req_i, cpu_addr_i, cpu_write_i and cpu_wdata_i stable while stalled; the controller samples the address live every cycle.
- If cpu_req_i drops mid-miss, the current memory transaction still completes and the line is installed.
- mem_req_o, mem_write_o and mem_addr_o stay stable from the first request cycle until the ack cycle inclusive.
- mem_ack_i in IDLE is ignored.
- In non-request cycles mem_addr_o and mem_wdata_o are driven 0.
- cpu_rdata_o = 0 whenever not (cpu_req_i && !cpu_write_i && hit && IDLE).
- Reset mid-transaction:
  - FSM returns to IDLE; mem_req_o = 0 the next cycle.
  - All lines invalidated; dirty data is lost by design.
  - A late mem_ack_i is ignored.
- Simultaneous mem_ack_i and rst_i: reset wins; no array update.

Test Plan:
1. After reset, load 0x0000_0040 → stall high the same cycle, mem_req_o=1, mem_write_o=0, mem_addr_o=0x40. Ack after 10 cycles with word0=0x11111111 → stall low on the next cycle, cpu_rdata_o=0x11111111.
2. Store 0x0000_0044 = 0xDEADBEEF (hit) → no stall cycle. A following load of 0x44 returns 0xDEADBEEF.
3. Load 0x0000_0440 (index 2, tag 1, line dirty) → WRITEBACK to mem_addr_o=0x40 with word1 of mem_wdata_o=0xDEADBEEF, then ALLOCATE at 0x440; total stall = both latencies + 1.
4. Store miss to clean line 0x0000_0884 → single fetch at 0x880, then 0 extra stall in IDLE; word1 merged, dirty=1. A later conflict at 0x0084 triggers a writeback of 0x880.
5. Spurious mem_ack_i in IDLE, and ack with latency 1 → no state change for the spurious ack; latency-1 ack gives a 2-cycle stall.
6. Assert rst_i during WRITEBACK → mem_req_o=0 next cycle; load 0x40 misses again. An ack arriving after reset is ignored.
